// File: rtl/fb_pkg.sv
// fb_pkg: shared state type and default geometry for the frame-buffer scheduler
package fb_pkg;
  typedef enum logic {RUN, CLEAR} state_e;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LINE_BYTES = 64;
  localparam int DEF_COL_W = $clog2(DEF_LINE_BYTES);
  localparam int DEF_LINE_W = DEF_ADDR_WIDTH - DEF_COL_W;
endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: line/column counter with frame/line restart, step, column wrap and sticky end-of-line flag
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int COL_W = DEF_COL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    line_start,
  input  logic                    step,
  output logic [LINE_W+COL_W-1:0] addr,
  output logic                    eol
);
  logic [LINE_W-1:0] line_q, line_d, line_e;
  logic [COL_W-1:0] col_q, col_d, col_e;
  logic eol_q, eol_d;
  always_comb begin
    line_e = frame_start ? '0 : line_start ? line_q + LINE_W'(1) : line_q;
    col_e = (frame_start | line_start) ? '0 : col_q;
    eol = (frame_start | line_start) ? 1'b0 : eol_q;
    addr = {line_e, col_e};
    line_d = line_e;
    col_d = col_e + COL_W'(step);
    eol_d = eol | (step & (&col_e));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      col_q <= '0;
      eol_q <= 1'b0;
    end else begin
      line_q <= line_d;
      col_q <= col_d;
      eol_q <= eol_d;
    end
  end
endmodule

// File: rtl/fb_scheduler.sv
// fb_scheduler: turns capture bytes and VGA fetch strobes into frame-buffer RAM write/read cycles, with a clear sweep
module fb_scheduler
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_valid,
  output logic                  cap_ready,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  cap_line_start,
  input  logic                  cap_frame_start,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  line_overrun,
  input  logic                  vga_rd_en,
  input  logic                  vga_line_start,
  input  logic                  vga_frame_start,
  output logic                  pix_valid,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr
);
  localparam int COL_W = $clog2(LINE_BYTES);
  localparam int LINE_W = ADDR_WIDTH - COL_W;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d, waddr_q, waddr_d, raddr_q, raddr_d, w_addr, r_addr;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic we_q, we_d, ovr_q, ovr_d, done_q, done_d, rv_q, rv_d, pv_q, pv_d;
  logic run, accept, last, w_eol, rd_eol_unused;
  fb_addr_gen #(.LINE_W(LINE_W), .COL_W(COL_W)) u_wgen (
    .clk(clk), .rst(rst),
    .frame_start((run & cap_frame_start) | last),
    .line_start(run & cap_line_start),
    .step(accept),
    .addr(w_addr), .eol(w_eol)
  );
  fb_addr_gen #(.LINE_W(LINE_W), .COL_W(COL_W)) u_rgen (
    .clk(clk), .rst(rst),
    .frame_start(vga_frame_start),
    .line_start(vga_line_start),
    .step(vga_rd_en),
    .addr(r_addr), .eol(rd_eol_unused)
  );
  always_comb begin
    run = state_q == RUN;
    accept = cap_valid & run;
    last = ~run & (&sweep_q);
    state_d = run ? (clear_req ? CLEAR : RUN) : (last ? RUN : CLEAR);
    sweep_d = run ? '0 : sweep_q + ADDR_WIDTH'(1);
    we_d = run ? accept & ~w_eol : 1'b1;
    waddr_d = run ? w_addr : sweep_q;
    din_d = run ? cap_data : '0;
    ovr_d = ovr_q | (accept & w_eol);
    done_d = last;
    raddr_d = vga_rd_en ? r_addr : raddr_q;
    rv_d = vga_rd_en;
    pv_d = rv_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      sweep_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      din_q <= '0;
      ovr_q <= 1'b0;
      done_q <= 1'b0;
      raddr_q <= '0;
      rv_q <= 1'b0;
      pv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      din_q <= din_d;
      ovr_q <= ovr_d;
      done_q <= done_d;
      raddr_q <= raddr_d;
      rv_q <= rv_d;
      pv_q <= pv_d;
    end
  end
  assign cap_ready = run;
  assign clear_busy = ~run;
  assign clear_done = done_q;
  assign line_overrun = ovr_q;
  assign pix_valid = pv_q;
  assign ram_we = we_q;
  assign ram_waddr = waddr_q;
  assign ram_din = din_q;
  assign ram_raddr = raddr_q;
endmodule

// File: tb/tb_fb_scheduler.sv
// tb_fb_scheduler: table-driven and scoreboard checks of capture writes, overrun, read latency and clear sweep
module tb_fb_scheduler;
  localparam int AW = 14;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst, cap_valid, cap_ready, cap_line_start, cap_frame_start, clear_req, clear_busy, clear_done;
  logic line_overrun, vga_rd_en, vga_line_start, vga_frame_start, pix_valid, ram_we;
  logic [DW-1:0] cap_data, ram_din, dout;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct {bit fs; bit ls; bit v; logic [DW-1:0] d; bit ew; int ea;} vec_t;
  wr_t q[$];
  wr_t mon_e;
  vec_t tbl[8];
  int total = 0;
  int bad = 0;
  int sweep_exp = 0;
  int done_cnt = 0;
  bit sweep_on = 1'b0;
  always #5 clk = ~clk;
  fb_scheduler dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data),
    .cap_line_start(cap_line_start), .cap_frame_start(cap_frame_start), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done), .line_overrun(line_overrun),
    .vga_rd_en(vga_rd_en), .vga_line_start(vga_line_start), .vga_frame_start(vga_frame_start),
    .pix_valid(pix_valid), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_raddr(ram_raddr)
  );
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    dout <= mem[ram_raddr];
  end
  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (clear_done === 1'b1) done_cnt++;
    if (ram_we === 1'b1) begin
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("wr_addr", int'(ram_waddr), int'(mon_e.a));
        chk("wr_data", int'(ram_din), int'(mon_e.d));
      end else if (sweep_on) begin
        chk("sweep_addr", int'(ram_waddr), sweep_exp);
        chk("sweep_data", int'(ram_din), 0);
        sweep_exp++;
      end else chk("unexpected_write", 1, 0);
    end
  end
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic samp();
    @(negedge clk);
    #1;
  endtask
  task automatic cap(bit fs, bit ls, bit v, logic [DW-1:0] d);
    cap_frame_start = fs;
    cap_line_start = ls;
    cap_valid = v;
    cap_data = d;
    cyc();
    cap_frame_start = 1'b0;
    cap_line_start = 1'b0;
    cap_valid = 1'b0;
  endtask
  task automatic push(int a, logic [DW-1:0] d);
    q.push_back('{a: AW'(a), d: d});
  endtask
  task automatic chk_reset_outs(string tag);
    chk({tag, "_we"}, int'(ram_we), 0);
    chk({tag, "_waddr"}, int'(ram_waddr), 0);
    chk({tag, "_din"}, int'(ram_din), 0);
    chk({tag, "_raddr"}, int'(ram_raddr), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_clear_done"}, int'(clear_done), 0);
    chk({tag, "_clear_busy"}, int'(clear_busy), 0);
    chk({tag, "_overrun"}, int'(line_overrun), 0);
    chk({tag, "_cap_ready"}, int'(cap_ready), 1);
  endtask
  initial begin
    int n;
    bit got, busy_ok;
    rst = 1'b1;
    {cap_valid, cap_line_start, cap_frame_start, clear_req, vga_rd_en, vga_line_start, vga_frame_start} = '0;
    cap_data = '0;
    cyc(2);
    rst = 1'b0;
    samp();
    chk_reset_outs("reset");
    tbl[0] = '{1, 0, 1, 8'hA1, 1, 0};
    tbl[1] = '{0, 0, 1, 8'hA2, 1, 1};
    tbl[2] = '{0, 0, 1, 8'hA3, 1, 2};
    tbl[3] = '{0, 0, 0, 8'h00, 0, 0};
    tbl[4] = '{1, 1, 1, 8'h11, 1, 0};
    tbl[5] = '{0, 1, 1, 8'h22, 1, 64};
    tbl[6] = '{0, 1, 0, 8'h00, 0, 0};
    tbl[7] = '{0, 0, 1, 8'h33, 1, 128};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ew) push(tbl[i].ea, tbl[i].d);
      cap(tbl[i].fs, tbl[i].ls, tbl[i].v, tbl[i].d);
    end
    cyc(2);
    samp();
    chk("table_drained", q.size(), 0);
    cap(1, 0, 0, 8'h00);
    for (int i = 0; i < 65; i++) begin
      if (i < 64) push(64 + i, DW'(i));
      cap(0, i == 0, 1, DW'(i));
      if (i == 63) begin
        samp();
        chk("overrun_before", int'(line_overrun), 0);
      end
    end
    samp();
    chk("overrun_set", int'(line_overrun), 1);
    cyc(3);
    cap(0, 1, 0, 8'h00);
    samp();
    chk("overrun_sticky", int'(line_overrun), 1);
    chk("overrun_drained", q.size(), 0);
    cap(1, 0, 0, 8'h00);
    cap(0, 1, 0, 8'h00);
    push(128, 8'h00);
    cap(0, 1, 1, 8'h00);
    push(129, 8'h00);
    cap(0, 0, 1, 8'h00);
    push(130, 8'h5A);
    cap(0, 0, 1, 8'h5A);
    cyc(3);
    vga_frame_start = 1'b1;
    cyc();
    vga_frame_start = 1'b0;
    vga_line_start = 1'b1;
    cyc(2);
    vga_line_start = 1'b0;
    vga_rd_en = 1'b1;
    cyc(2);
    vga_rd_en = 1'b0;
    cyc(3);
    samp();
    chk("pix_idle", int'(pix_valid), 0);
    vga_rd_en = 1'b1;
    cyc();
    vga_rd_en = 1'b0;
    samp();
    chk("rd_raddr", int'(ram_raddr), 130);
    chk("pix_early", int'(pix_valid), 0);
    samp();
    chk("pix_valid", int'(pix_valid), 1);
    chk("rd_dout", int'(dout), 'h5A);
    samp();
    chk("pix_drop", int'(pix_valid), 0);
    chk("read_drained", q.size(), 0);
    push(0, 8'h77);
    sweep_on = 1'b1;
    sweep_exp = 0;
    clear_req = 1'b1;
    cap(1, 0, 1, 8'h77);
    clear_req = 1'b0;
    n = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && n < 20000) begin
      samp();
      n++;
      if (clear_done) got = 1'b1;
      else if (clear_busy !== 1'b1 || cap_ready !== 1'b0) busy_ok = 1'b0;
      if (n == 500) begin
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
      end
    end
    chk("clear_done_seen", int'(got), 1);
    chk("clear_busy_hold", int'(busy_ok), 1);
    chk("done_cap_ready", int'(cap_ready), 1);
    chk("done_clear_busy", int'(clear_busy), 0);
    chk("sweep_count", sweep_exp, 1 << AW);
    sweep_on = 1'b0;
    push(0, 8'h99);
    cap(0, 0, 1, 8'h99);
    samp();
    chk("done_one_cycle", int'(clear_done), 0);
    chk("done_count", done_cnt, 1);
    cyc(2);
    samp();
    chk("clear_drained", q.size(), 0);
    sweep_on = 1'b1;
    sweep_exp = 0;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      samp();
      n++;
      if (ram_we && ram_waddr == AW'(1000)) got = 1'b1;
    end
    chk("sweep_reached_1000", int'(got), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    samp();
    sweep_on = 1'b0;
    chk_reset_outs("midclear");
    cyc(5);
    samp();
    chk("midclear_no_done", done_cnt, 1);
    chk("midclear_run", int'(clear_busy), 0);
    push(0, 8'h42);
    cap(1, 0, 1, 8'h42);
    cyc(3);
    samp();
    chk("final_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_scheduler.md
# fb_scheduler

Frame-buffer scheduler for the 16K×8 dual-port RAM that holds the captured HP display image. It turns the capture byte stream (with line/frame markers) into RAM write cycles and turns the VGA pixel-fetch strobes into RAM read addresses. It also runs a full-buffer clear sweep that pre-empts capture. It sits between the capture front end and the RAM on the write port, and between the VGA timing generator and the RAM on the read port.

## Interface
- `ADDR_WIDTH`, 14: RAM address width; the buffer holds 2^ADDR_WIDTH bytes.
- `DATA_WIDTH`, 8: byte width.
- `LINE_BYTES`, 64: bytes per display line; must be a power of 2. COL_W = log2(LINE_BYTES), LINE_W = ADDR_WIDTH − COL_W.

Ports:
- `clk` in 1: single clock; both RAM ports are driven from it.
- `rst` in 1: synchronous, active-high reset.
- `cap_valid` in 1: capture byte present.
- `cap_ready` out 1: byte accepted when `cap_valid && cap_ready`.
- `cap_data` in DATA_WIDTH: capture byte.
- `cap_line_start` in 1: current or next byte is column 0 of the next line.
- `cap_frame_start` in 1: current or next byte is line 0, column 0.
- `clear_req` in 1: start the clear sweep (single-cycle pulse).
- `clear_busy` out 1: sweep in progress.
- `clear_done` out 1: one-cycle pulse when the sweep completes.
- `line_overrun` out 1: sticky; a capture line exceeded LINE_BYTES.
- `vga_rd_en` in 1: fetch the next pixel byte.
- `vga_line_start` in 1: read column 0 of the next line.
- `vga_frame_start` in 1: read line 0, column 0.
- `pix_valid` out 1: RAM `dout` holds the requested byte.
- `ram_we` out 1: RAM write enable.
- `ram_waddr` out ADDR_WIDTH: RAM write address.
- `ram_din` out DATA_WIDTH: RAM write data.
- `ram_raddr` out ADDR_WIDTH: RAM read address.

## Operation
- FSM has two states, RUN and CLEAR. The reset state is RUN.
- `cap_ready` = (state == RUN). `clear_busy` = (state == CLEAR).
- **Write counters** (`wline`, `wcol`); the address is {wline, wcol}.
  - A start marker is applied before any byte accepted in the same cycle.
  - `cap_frame_start` sets wline=0, wcol=0.
  - `cap_line_start` (without frame_start) sets wline+1 (wraps at 2^LINE_W) and wcol=0.
  - When both markers are asserted, frame_start wins.
  - An accepted byte is written at {wline, wcol}, then wcol increments.
  - After LINE_BYTES bytes in a line, further bytes are accepted but dropped (no write), and `line_overrun` is set. `line_overrun` is cleared only by `rst`.
  - Markers are honoured in RUN even when `cap_valid` is low. They are ignored in CLEAR.
- **CLEAR**
  - `clear_req` in RUN moves to CLEAR on the next cycle.
  - Each cycle writes `ram_din`=0 at sweep address 0, 1, …, 2^ADDR_WIDTH−1.
  - After the last address: return to RUN, pulse `clear_done`, reset wline=0 and wcol=0.
  - `clear_req` during CLEAR is ignored. A `clear_req` that arrives in the same cycle as an accepted capture byte: the byte is written first, then the FSM enters CLEAR.
- **Read counters** (`rline`, `rcol`) follow the same marker rules from the vga_* inputs.
  - `vga_rd_en` reads {rline, rcol}, then rcol increments; rcol wraps at LINE_BYTES with no flag.
  - Reads run in both states. Read/write collision on one address is resolved by the RAM; this block does no ordering.

## Timing
- **Reset values:** `ram_we`=0, `ram_waddr`=0, `ram_din`=0, `ram_raddr`=0, `pix_valid`=0, `clear_done`=0, `clear_busy`=0, `line_overrun`=0, `cap_ready`=1. All counters are 0.
- **Write path:** registered. An accepted byte at edge N appears as `ram_we`/`ram_waddr`/`ram_din` during cycle N+1, and is in the RAM after edge N+2.
- **Read path:** `ram_raddr` is registered at the edge that samples `vga_rd_en`. The RAM registers `dout` one edge later. `pix_valid` is asserted 2 cycles after `vga_rd_en`, so back-to-back reads give one byte per cycle.
- **Clear:** the first zero write is in the cycle after the one where CLEAR is entered. The sweep lasts exactly 2^ADDR_WIDTH cycles of `ram_we`=1. `clear_done` is high in the first RUN cycle. `cap_ready` returns to 1 in that same cycle.
- **Reset mid-clear:** the next cycle is in RUN with `ram_we`=0. No `clear_done` pulse is generated. The buffer contents are left partially cleared.

## Structure
- Package `fb_pkg`:
  - state enum {RUN, CLEAR}
  - default constants for ADDR_WIDTH, DATA_WIDTH and LINE_BYTES
  - derived COL_W / LINE_W
- Sub-module `fb_addr_gen` holds the line/column counter with frame/line start, step enable, wrap and an end-of-line flag.
  - It is instantiated twice, once for write and once for read.
  - The overrun drop logic stays in the top level.

## Test plan
- **Basic write:** reset; frame_start + 3 bytes 0xA1, 0xA2, 0xA3 → `ram_waddr` 0, 1, 2 with matching `ram_din`, each one cycle after acceptance.
- **Line advance and overrun:** line_start then 65 bytes.
  - Writes land at 64..127.
  - The 65th byte gives no write and sets `line_overrun`=1, which stays set.
- **Read latency:** after writing 0x5A at address 130, vga_frame_start, two line_starts, then rd_en at column 2 → `ram_raddr`=130, `pix_valid` 2 cycles later with `dout`=0x5A.
- **Clear:**
  - `clear_req` mid-capture → `cap_ready`=0 for the sweep.
  - The bench sees 16384 zero writes at addresses 0..16383.
  - Then `clear_done` pulses once and the next accepted byte is written to address 0.
- **Simultaneous markers:** frame_start + line_start + byte 0x11 in one cycle → written at address 0.
- **Reset mid-clear:** assert `rst` at sweep address 1000 → `ram_we`=0 the next cycle, state RUN, no `clear_done`, all outputs at their reset values.
